bitwise_and_32b: RTL and testbench
==================================

# bitwise_and_32b

Registered 32-bit bitwise-AND unit for the ALU datapath. Each accepted operand pair `i0`, `i1` produces `result = i0 & i1` plus a zero flag, delivered through a one-entry output register with valid/ready flow control. The combinational core is built structurally from 32 two-input AND cells, one per bit, consistent with the ALU's gate-level style. The block sits beside the other ALU function units, and its output feeds the ALU result multiplexer.

## Interface
- No parameters; width fixed at 32.
- `clk`  input  1  rising-edge clock, sole clock.
- `rst_n`  input  1  synchronous reset, active-low, sampled on rising `clk`.
- `in_valid`  input  1  operand pair on `i0`/`i1` is valid.
- `in_ready`  output  1  unit can accept an operand pair this cycle.
- `i0`  input  32  operand A.
- `i1`  input  32  operand B.
- `out_valid`  output  1  `result`/`zero` hold a valid, unconsumed value.
- `out_ready`  input  1  downstream consumes the result this cycle.
- `result`  output  32  registered `i0 & i1`.
- `zero`  output  1  registered flag, 1 when the AND result is 0x00000000.

## Operation
- Core: `and_bit[k] = i0[k] & i1[k]` for k = 0..31, implemented as 32 instantiated 2-input AND cells. No carries and no cross-bit interaction.
- Zero: `zero_next = ~|and_bit` (32-input NOR over the core output).
- Accept condition: `accept = in_valid & in_ready`.
- `in_ready = ~out_valid | out_ready`. This is combinational from the output-register state and `out_ready`, and allows a new accept in the same cycle the held result drains.
- Drain condition: `drain = out_valid & out_ready`.
- Register update on each rising `clk` while `rst_n` = 1:
  - accept: load `result` ← `and_bit` and `zero` ← `zero_next`, and set `out_valid` ← 1. This applies regardless of `drain`.
  - drain with no accept: `out_valid` ← 0, and `result`/`zero` keep their last value.
  - neither: all registers hold.
- While `out_valid` = 1 and `out_ready` = 0:
  - `result`/`zero` stay stable.
  - `in_ready` = 0.
  - Operand inputs are ignored.
- `i0`/`i1` are don't-care when `in_valid` = 0. Only accepted data reaches the outputs.
- Unsigned/bitwise semantics only; no sign handling.

## Timing
- Latency: result is visible with `out_valid` = 1 in the cycle after the accepting edge (1 cycle).
- Throughput: one operation per cycle when `out_ready` is held at 1.
- Reset: when `rst_n` = 0 at a rising edge:
  - `out_valid` ← 0, `result` ← 32'h0000_0000, `zero` ← 1.
  - `in_ready` reads 1 after reset.
  - Reset overrides any simultaneous accept or drain.
- Reset mid-operation: a held, undrained result is discarded, with no output pulse.
- Simultaneous accept and drain: the old result is consumed, the new result is loaded, and `out_valid` stays 1 (no bubble).
- No combinational path from `i0`/`i1` to any output. The only combinational output path is `out_ready` → `in_ready`.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `in_valid` = 1 -> `out_valid` = 0, `result` = 0x00000000, `zero` = 1, `in_ready` = 1.
- Vectors with `out_ready` held at 1, one per cycle -> each result appears one cycle later, back-to-back with no bubbles:
  - 0x00000000 & 0xFFFFFFFF -> 0x00000000, `zero` = 1.
  - 0x07C1E0E7 & 0x80104308 -> 0x00004000, `zero` = 0.
  - 0x00011441 & 0x100BEFEF -> 0x00010441.
  - 0x54001000 & 0xE0001FFF -> 0x40001000.
- Backpressure: accept 0xFFFFFFFF & 0x12345678, hold `out_ready` = 0 for 3 cycles while changing inputs ->
  - `result` stays 0x12345678 and `in_ready` = 0.
  - Release `out_ready` -> drains, and the next pair is accepted in the same cycle.
- Walking one: `i0` = `i1` = 1<<k for k = 0..31 -> `result` = 1<<k. Walking one against its complement, `i0` = 1<<k, `i1` = ~(1<<k) -> `result` = 0, `zero` = 1.
- Reset mid-operation: accept 0xAAAAAAAA & 0xFFFF0000 with `out_ready` = 0, then pulse `rst_n` = 0 -> `out_valid` = 0, `result` = 0, and no stale output afterwards.

Source files
------------

// File: rtl/bitwise_and_32b.sv
// Registered 32-bit bitwise AND unit with a one-entry valid/ready output stage.
// The core is built from 32 structural two-input AND cells, one per bit.

module and2_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

module bitwise_and_32b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] i0,
  input  logic [31:0] i1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero
);

  logic [31:0] and_bit;
  logic        zero_next;
  logic        accept;
  logic        drain;

  genvar k;
  generate
    for (k = 0; k < 32; k++) begin : g_and
      and2_cell u_and (
        .a (i0[k]),
        .b (i1[k]),
        .y (and_bit[k])
      );
    end
  endgenerate

  assign zero_next = ~|and_bit;

  // A held result that drains this cycle frees the slot for a same-cycle accept.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= 32'h0000_0000;
      zero      <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= and_bit;
      zero      <= zero_next;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_and_32b.sv
// Self-checking bench for bitwise_and_32b: expected results are queued on
// accept and compared when the output register presents them.

module tb_bitwise_and_32b;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] i0;
  logic [31:0] i1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  typedef struct {
    logic [31:0] res;
    logic        z;
  } item_t;

  item_t       sb[$];
  item_t       last;
  logic [31:0] exp_cur;
  logic        model_valid;
  logic        known;
  int          num_checks;
  int          num_fails;

  bitwise_and_32b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i0        (i0),
    .i1        (i1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    i0       = a;
    i1       = b;
    exp_cur  = exp;
    in_valid = 1'b1;
  endtask

  // Scoreboard: compare state left by the last edge, then predict the next edge.
  always @(negedge clk) begin
    if (known) begin
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, model_valid});
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (!model_valid || out_ready)});
      if (model_valid) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", sb.size(), 1);
        end else begin
          checkOutput("result", result, sb[0].res);
          checkOutput("zero", {31'b0, zero}, {31'b0, sb[0].z});
          if (out_ready) last = sb.pop_front();
        end
      end else begin
        checkOutput("result_hold", result, last.res);
        checkOutput("zero_hold", {31'b0, zero}, {31'b0, last.z});
      end
    end
    if (!rst_n) begin
      sb.delete();
      last.res    = 32'h0;
      last.z      = 1'b1;
      model_valid = 1'b0;
      known       = 1'b1;
    end else if (known) begin
      if (in_valid && (!model_valid || out_ready)) begin
        sb.push_back('{res: exp_cur, z: (exp_cur == 32'h0)});
        model_valid = 1'b1;
      end else if (model_valid && out_ready) begin
        model_valid = 1'b0;
      end
    end
  end

  initial begin
    num_checks  = 0;
    num_fails   = 0;
    known       = 1'b0;
    model_valid = 1'b0;
    rst_n       = 1'b0;
    out_ready   = 1'b1;
    applyStimulus(32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF);

    stepCycle();
    stepCycle();
    @(negedge clk);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_result", result, 32'h0000_0000);
    checkOutput("rst_zero", {31'b0, zero}, 32'd1);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back vectors with the consumer always ready.
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    stepCycle();
    applyStimulus(32'h07C1_E0E7, 32'h8010_4308, 32'h0000_4000);
    stepCycle();
    applyStimulus(32'h0001_1441, 32'h100B_EFEF, 32'h0001_0441);
    stepCycle();
    applyStimulus(32'h5400_1000, 32'hE000_1FFF, 32'h4000_1000);
    stepCycle();
    in_valid = 1'b0;
    stepCycle();

    // Backpressure: result must hold while operands change underneath.
    out_ready = 1'b0;
    applyStimulus(32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678);
    stepCycle();
    for (int n = 0; n < 3; n++) begin
      applyStimulus(32'hFFFF_0000 ^ n, 32'h0F0F_F0F0, 32'hBAD0_BAD0);
      @(negedge clk);
      checkOutput("bp_result", result, 32'h1234_5678);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
      stepCycle();
    end
    out_ready = 1'b1;
    applyStimulus(32'h0F0F_0F0F, 32'hFF00_FF00, 32'h0F00_0F00);
    @(negedge clk);
    checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);
    stepCycle();
    @(negedge clk);
    checkOutput("release_result", result, 32'h0F00_0F00);
    stepCycle();
    in_valid = 1'b0;
    stepCycle();

    // Walking one, against itself and against its complement.
    for (int k = 0; k < 32; k++) begin
      applyStimulus(32'h1 << k, 32'h1 << k, 32'h1 << k);
      stepCycle();
      applyStimulus(32'h1 << k, ~(32'h1 << k), 32'h0);
      stepCycle();
    end
    in_valid = 1'b0;
    stepCycle();

    // Reset while an undrained result is held.
    out_ready = 1'b0;
    applyStimulus(32'hAAAA_AAAA, 32'hFFFF_0000, 32'hAAAA_0000);
    stepCycle();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("held_result", result, 32'hAAAA_0000);
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_result", result, 32'h0000_0000);
    checkOutput("midrst_zero", {31'b0, zero}, 32'd1);
    for (int n = 0; n < 4; n++) stepCycle();

    @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
